// File: rtl/disp_pkg.sv
// disp_pkg: shared digit codes, converter FSM states and scratch sizing helper
package disp_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_ERR   = 4'hE;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} cnv_state_t;

    // Number of decimal digits needed to hold 2**width-1
    function automatic int ndig_full(input int width);
        logic [63:0] v;
        int          n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_adjust_digit.sv
// bcd_adjust_digit: double-dabble add-3 correction for one BCD nibble
module bcd_adjust_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = din >= 4'd5 ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: iterative binary-to-BCD converter feeding 7-segment decoders.
// Optional macro LEADING_BLANK_EN blanks leading zero digits (units digit always shown).
module bin_to_bcd_display
    import disp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digits
);

    // Scratch is padded up to DIGITS so the presented slice always exists
    localparam int NDIG = ndig_full(WIDTH) > DIGITS ? ndig_full(WIDTH) : DIGITS;
    localparam int SW   = 4 * NDIG;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = 64'd10 ** DIGITS;

    cnv_state_t          state_q, state_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [SW-1:0]       scr_q, scr_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_r_q, ovf_r_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [4*DIGITS-1:0] digits_q, digits_d, shown;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_adjust_digit u_adj (
            .din  (scr_q[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // Presented digits, with optional blanking of leading zeros above the units digit
`ifdef LEADING_BLANK_EN
    logic lead;
    always_comb begin
        shown = scr_q[4*DIGITS-1:0];
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead && (shown[4*i +: 4] == 4'h0);
            if (lead) shown[4*i +: 4] = DIG_BLANK;
        end
    end
`else
    always_comb begin
        shown = scr_q[4*DIGITS-1:0];
    end
`endif

    // Next-state and next-output logic of the conversion FSM
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_r_d    = ovf_r_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    ovf_r_d = 64'(bin_in) >= LIMIT;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, sh_d} = {adj, sh_q} << 1;
                cnt_d         = cnt_q + 1'b1;
                state_d       = cnt_q == CW'(WIDTH - 1) ? FINISH : SHIFT;
            end
            FINISH: begin
                digits_d   = ovf_r_q ? {DIGITS{DIG_ERR}} : shown;
                overflow_d = ovf_r_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers; reset aborts any conversion and darkens the display
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_r_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= {DIGITS{DIG_BLANK}};
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_r_q    <= ovf_r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign digits   = digits_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb_bin_to_bcd_display: scoreboard bench for the binary-to-BCD display converter
module tb_bin_to_bcd_display;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [15:0] digits;

    logic        s8 = 1'b0;
    logic [7:0]  b83 = '0, b82 = '0;
    logic        bz3, dn3, ov3, bz2, dn2, ov2;
    logic [11:0] d3;
    logic [7:0]  d2;

    int   n_cmp = 0, n_err = 0, cyc = 0, next_free = 0, last_acc = -100, n_done = 0;
    logic done_prev = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic        ov;
        int          due;
    } exp_t;
    exp_t sb[$];

    bin_to_bcd_display #(.WIDTH(16), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .overflow(overflow), .digits(digits)
    );

    bin_to_bcd_display #(.WIDTH(8), .DIGITS(3)) dut83 (
        .clk(clk), .rst(rst), .start(s8), .bin_in(b83),
        .busy(bz3), .done(dn3), .overflow(ov3), .digits(d3)
    );

    bin_to_bcd_display #(.WIDTH(8), .DIGITS(2)) dut82 (
        .clk(clk), .rst(rst), .start(s8), .bin_in(b82),
        .busy(bz2), .done(dn2), .overflow(ov2), .digits(d2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of b, error code when it does not fit four digits
    function automatic logic [16:0] exp_of(input logic [15:0] b);
        logic [15:0] d;
        int          v;
`ifdef LEADING_BLANK_EN
        logic        lead;
`endif
        if (b >= 16'd10000) return {1'b1, 16'hEEEE};
        v = int'(b);
        for (int i = 0; i < 4; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
`ifdef LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            lead = lead && (d[4*i +: 4] == 4'h0);
            if (lead) d[4*i +: 4] = 4'hF;
        end
`endif
        return {1'b0, d};
    endfunction

    // Drive one cycle of stimulus; the protocol model decides whether the DUT accepts it
    task automatic step(input logic s, input logic [15:0] b);
        exp_t e;
        start  = s;
        bin_in = b;
        if (s && !rst && cyc >= next_free) begin
            {e.ov, e.d} = exp_of(b);
            e.due       = cyc + 18;
            sb.push_back(e);
            last_acc  = cyc;
            next_free = cyc + 18;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Result monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done_prev) chk("done_width", 64'(done), 64'd0);
        if (done) begin
            n_done++;
            if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("digits", 64'(digits), 64'(e.d));
                chk("overflow", 64'(overflow), 64'(e.ov));
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
        done_prev = done;
    end

    initial begin
        int nd, k;
        logic [15:0] vals[5] = '{16'd9999, 16'd10000, 16'd65535, 16'd42, 16'd0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_digits", 64'(digits), 64'hFFFF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_digits83", 64'(d3), 64'hFFF);

        step(1'b1, 16'd1234);
        step(1'b0, 16'd0);
        drain();

        foreach (vals[i]) begin
            step(1'b1, vals[i]);
            step(1'b0, 16'd0);
            drain();
        end

        for (int i = 0; i < 60; i++) begin
            chk("busy_hold", 64'(busy), 64'(cyc > last_acc && cyc < last_acc + 18));
            step(1'b1, 16'($urandom_range(0, 65535)));
        end
        step(1'b0, 16'd0);
        drain();

        step(1'b1, 16'd5678);
        repeat (6) step(1'b0, 16'd0);
        rst = 1'b1;
        sb.delete();
        next_free = 0;
        step(1'b0, 16'd0);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_digits", 64'(digits), 64'hFFFF);
        chk("abort_done", 64'(done), 64'd0);
        nd = n_done;
        repeat (25) step(1'b0, 16'd0);
        chk("abort_no_done", 64'(n_done), 64'(nd));
        step(1'b1, 16'd321);
        step(1'b0, 16'd0);
        drain();

        b83 = 8'd255;
        b82 = 8'd100;
        s8  = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        k  = 1;
        while (!dn3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_latency", 64'(k), 64'd10);
        chk("sweep83_digits", 64'(d3), 64'h255);
        chk("sweep83_overflow", 64'(ov3), 64'd0);
        chk("sweep83_busy", 64'(bz3), 64'd0);
        chk("sweep82_done", 64'(dn2), 64'd1);
        chk("sweep82_digits", 64'(d2), 64'hEE);
        chk("sweep82_overflow", 64'(ov2), 64'd1);
        chk("sweep82_busy", 64'(bz2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
